// File: rtl/if_stage_pkg.sv
// if_stage_pkg: constants, state encoding and record types shared by the
// instruction-fetch stage and its skid buffer.
package if_stage_pkg;

  // All-zero word is the NOP (sll $0,$0,0) injected as a pipeline bubble
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // S_FETCH: request at pc; S_HOLD: word parked in skid, no request;
  // S_DROP: request in flight for a stale address, its data is thrown away
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } if_state_e;

  // One fetched word together with the PC+4 of its address
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_word_t;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc4: 32'h0};

  // Sequential PC advance; wraps modulo 2^32
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_skid.sv
// if_skid_buffer: one-entry {instr, pc4} holding register. Catches a word
// that memory returned while ID was stalled so the fetch is never lost.
module if_skid_buffer
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        valid
);

  // Clear wins over load: a kill in the same cycle discards the word
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage. Owns the PC, runs the imem
// req/ack handshake, and drives the IF/ID register. Handles stall, flush
// and jr redirect. Optional macro IF_PERF_CNT_EN adds perf_fetched and
// perf_stall event counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_jump,
  input  logic [31:0] jump_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  ifid_opcode,
  output logic [5:0]  ifid_func
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  if_state_e   state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_inc;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic [31:0] redirect_pc;
  logic        redirect, kill;
  ifid_t       ifid_q, ifid_din;
  logic        ifid_we;
  fetch_word_t skid_din, skid_dout;
  logic        skid_vld, skid_load, skid_clear;

  assign pc_inc      = pc_next(pc);
  // jr is only honoured when ID is actually moving
  assign redirect    = pc_jump && !stall;
  assign kill        = flush || redirect;
  assign redirect_pc = jump_target & ~32'h3;

  assign skid_din.instr = imem_rdata;
  assign skid_din.pc4   = pc_inc;

  // Request side depends on registered state only, never on ack/stall
  assign imem_req  = (state != S_HOLD);
  assign imem_addr = (state == S_DROP) ? drop_addr : pc;

  assign ifid_instr  = ifid_q.instr;
  assign ifid_pc4    = ifid_q.pc4;
  assign ifid_valid  = ifid_q.valid;
  assign ifid_opcode = ifid_q.instr[31:26];
  assign ifid_func   = ifid_q.instr[5:0];

  if_skid_buffer u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (skid_din),
    .dout  (skid_dout),
    .valid (skid_vld)
  );

  // Next-state, PC update and IF/ID load decisions; flush > jr > stall
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    ifid_din      = ifid_q;
    ifid_we       = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    case (state)
      S_FETCH: begin
        if (kill) begin
          ifid_din   = IFID_BUBBLE;
          ifid_we    = 1'b1;
          skid_clear = 1'b1;
          // flush refetches the same pc; jr moves to the target
          if (!flush) pc_nxt = redirect_pc;
          // Handshake still open: keep the old address until it completes
          if (!imem_ack) begin
            state_nxt     = S_DROP;
            drop_addr_nxt = pc;
          end
        end else if (imem_ack) begin
          pc_nxt = pc_inc;
          if (stall) begin
            skid_load = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            ifid_din = '{valid: 1'b1, instr: imem_rdata, pc4: pc_inc};
            ifid_we  = 1'b1;
          end
        end else if (!stall) begin
          ifid_din = IFID_BUBBLE;
          ifid_we  = 1'b1;
        end
      end
      S_HOLD: begin
        if (kill) begin
          ifid_din   = IFID_BUBBLE;
          ifid_we    = 1'b1;
          skid_clear = 1'b1;
          state_nxt  = S_FETCH;
          if (!flush) pc_nxt = redirect_pc;
        end else if (!stall) begin
          ifid_din   = '{valid: skid_vld, instr: skid_dout.instr, pc4: skid_dout.pc4};
          ifid_we    = 1'b1;
          skid_clear = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_DROP: begin
        if (kill) begin
          ifid_din   = IFID_BUBBLE;
          ifid_we    = 1'b1;
          skid_clear = 1'b1;
          if (!flush) pc_nxt = redirect_pc;
        end else if (!stall) begin
          ifid_din = IFID_BUBBLE;
          ifid_we  = 1'b1;
        end
        // Stale word arrives: discard it and start fetching at pc
        if (imem_ack) state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // State, PC and stale-address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (rst)          ifid_q <= IFID_BUBBLE;
    else if (ifid_we) ifid_q <= ifid_din;
  end

`ifdef IF_PERF_CNT_EN
  // Count valid IF/ID loads and stalled cycles; both wrap at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (ifid_we && ifid_din.valid) perf_fetched <= perf_fetched + 32'd1;
      if (stall)                     perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage. A reference model tracks the
// stream of instruction words ID should consume; a monitor pops and compares
// each consumed IF/ID entry. A second instance checks PC wrap from the top.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, flush, pc_jump;
  logic [31:0] jump_target;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  ifid_opcode, ifid_func;

  logic        hi_req, hi_valid;
  logic [31:0] hi_addr, hi_rdata, hi_instr, hi_pc4;
  logic [5:0]  hi_opcode, hi_func;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, hi_perf_fetched, hi_perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_pc;
  bit          stale;
  logic [31:0] stale_addr;
  logic        hs;
  bit          prev_pending;
  logic [31:0] prev_addr;
  logic [31:0] snap_addr;

  // Instruction memory contents: word index + 1
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  assign imem_rdata = mem_fn(imem_addr);
  assign hi_rdata   = mem_fn(hi_addr);

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .pc_jump     (pc_jump),
    .jump_target (jump_target),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .ifid_opcode (ifid_opcode),
    .ifid_func   (ifid_func)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (hi_req),
    .imem_addr   (hi_addr),
    .imem_ack    (1'b1),
    .imem_rdata  (hi_rdata),
    .stall       (1'b0),
    .flush       (1'b0),
    .pc_jump     (1'b0),
    .jump_target (32'h0),
    .ifid_instr  (hi_instr),
    .ifid_pc4    (hi_pc4),
    .ifid_valid  (hi_valid),
    .ifid_opcode (hi_opcode),
    .ifid_func   (hi_func)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched (hi_perf_fetched),
    .perf_stall   (hi_perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: ID consumes IF/ID when valid, not stalled and not flushed
  always @(negedge clk) begin
    if (!rst) begin
      if (!ifid_valid) check("bubble_instr", ifid_instr, 32'h0);
      if (q.size() >= 2) check("req_while_full", 32'(imem_req), 32'h0);
      if (prev_pending) begin
        check("req_held", 32'(imem_req), 32'h1);
        check("addr_held", imem_addr, prev_addr);
      end
      if (ifid_valid && !stall && !flush) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h pc4 %h expected none", ifid_instr, ifid_pc4);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("ifid_instr", ifid_instr, e.instr);
          check("ifid_pc4", ifid_pc4, e.pc4);
          check("ifid_opcode", 32'(ifid_opcode), 32'(e.instr[31:26]));
          check("ifid_func", 32'(ifid_func), 32'(e.instr[5:0]));
        end
      end
    end
    prev_pending = !rst && imem_req && !imem_ack;
    prev_addr    = imem_addr;
  end

  // Reference model: which words are fetched in order and which get killed
  always @(negedge clk) begin
    #2;
    if (rst) begin
      q.delete();
      model_pc = 32'h0;
      stale    = 1'b0;
    end else begin
      hs = imem_req && imem_ack;
      if (hs) check("fetch_addr", imem_addr, stale ? stale_addr : model_pc);
      if (flush || (pc_jump && !stall)) begin
        q.delete();
        if (hs) stale = 1'b0;
        else if (imem_req && !stale) begin
          stale      = 1'b1;
          stale_addr = model_pc;
        end
        if (!flush) model_pc = jump_target & ~32'h3;
      end else if (hs) begin
        if (stale) stale = 1'b0;
        else begin
          q.push_back('{instr: mem_fn(model_pc), pc4: model_pc + 32'd4});
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; flush = 1'b0;
    pc_jump = 1'b0; jump_target = 32'h0;
    repeat (2) @(posedge clk);
    smp();
    check("rst_valid", 32'(ifid_valid), 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);

    // c1: first request right after reset
    step(); rst = 1'b0; imem_ack = 1'b1;
    smp();
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("hi_first_addr", hi_addr, 32'hFFFF_FFFC);
    // c2, c3: back-to-back words
    step(); smp();
    check("b2b_instr1", ifid_instr, 32'd1);
    check("b2b_pc4_1", ifid_pc4, 32'd4);
    check("hi_wrap_addr", hi_addr, 32'h0);
    check("hi_wrap_pc4", hi_pc4, 32'h0);
    check("hi_wrap_instr", hi_instr, 32'h4000_0000);
`ifdef IF_PERF_CNT_EN
    check("hi_perf_fetched", hi_perf_fetched, 32'd1);
    check("hi_perf_stall", hi_perf_stall, 32'd0);
`endif
    step(); smp();
    check("b2b_instr2", ifid_instr, 32'd2);
    check("b2b_pc4_2", ifid_pc4, 32'd8);

    // c4..c6 stall: word 4 parks in the skid, IF/ID keeps word 3
    step(); stall = 1'b1; smp();
    check("stall_instr", ifid_instr, 32'd3);
    for (int k = 0; k < 2; k++) begin
      step(); smp();
      check("stall_frozen_instr", ifid_instr, 32'd3);
      check("stall_frozen_pc4", ifid_pc4, 32'd12);
      check("hold_no_req", 32'(imem_req), 32'h0);
    end
    step(); stall = 1'b0; smp();
    check("release_no_req", 32'(imem_req), 32'h0);
    step(); smp();
    check("skid_instr", ifid_instr, 32'd4);
    check("skid_pc4", ifid_pc4, 32'd16);
    step(); smp();
    check("resume_instr", ifid_instr, 32'd5);

    // jr to unaligned 0x103: fetch at 0x100, one bubble
    step(); pc_jump = 1'b1; jump_target = 32'h0000_0103; smp();
    step(); pc_jump = 1'b0; smp();
    check("jump_addr", imem_addr, 32'h0000_0100);
    check("jump_bubble_valid", 32'(ifid_valid), 32'h0);
    check("jump_bubble_instr", ifid_instr, 32'h0);
    step(); smp();
    check("jump_target_instr", ifid_instr, 32'h41);
    check("jump_target_pc4", ifid_pc4, 32'h104);

    // jr with ack withheld two cycles: old address held, word dropped
    step(); imem_ack = 1'b0; pc_jump = 1'b1; jump_target = 32'h200; smp();
    check("drop_addr0", imem_addr, 32'h108);
    step(); pc_jump = 1'b0; smp();
    check("drop_addr1", imem_addr, 32'h108);
    step(); imem_ack = 1'b1; smp();
    check("drop_addr2", imem_addr, 32'h108);
    step(); smp();
    check("after_drop_addr", imem_addr, 32'h200);
    check("after_drop_valid", 32'(ifid_valid), 32'h0);
    step(); smp();
    check("after_drop_instr", ifid_instr, 32'h81);

    // flush with stall while acked: bubble, pc re-requested
    step(); flush = 1'b1; stall = 1'b1; smp();
    snap_addr = imem_addr;
    check("flush_addr_pre", snap_addr, 32'h208);
    step(); flush = 1'b0; stall = 1'b0; smp();
    check("flush_bubble_valid", 32'(ifid_valid), 32'h0);
    check("flush_bubble_instr", ifid_instr, 32'h0);
    check("flush_refetch_addr", imem_addr, snap_addr);
`ifdef IF_PERF_CNT_EN
    check("perf_stall", perf_stall, 32'd4);
    check("perf_fetched", perf_fetched, 32'd10);
`endif

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      step();
      imem_ack    = ($urandom_range(0, 9) < 7);
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      pc_jump     = ($urandom_range(0, 11) == 0);
      jump_target = $urandom;
    end
    step();
    imem_ack = 1'b1; stall = 1'b0; flush = 1'b0; pc_jump = 1'b0;
    repeat (10) step();
    smp();
    check("drain_queue", 32'(q.size() <= 1), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, fetches instruction words over a request/acknowledge handshake to instruction memory, and drives the IF/ID pipeline register whose opcode/func fields feed the ID-stage controller. It honours stall and flush from hazard logic, and redirects the PC on a taken `jr` (PC_jump) resolved in ID.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held with stable imem_addr until imem_ack
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  request accepted; imem_rdata valid this cycle (may be same cycle as req)
- imem_rdata  in  32  instruction word
- stall  in  1  ID stalled: IF/ID must hold its contents
- flush  in  1  kill IF/ID contents and any buffered fetch
- pc_jump  in  1  taken jr from ID; redirect PC
- jump_target  in  32  redirect address (rs value)
- ifid_instr  out  32  IF/ID instruction (0 = NOP when invalid)
- ifid_pc4  out  32  IF/ID PC+4 of that instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_opcode  out  6  ifid_instr[31:26], to controller
- ifid_func  out  6  ifid_instr[5:0], to controller

## Operation
- States: S_FETCH (req=1, addr=pc), S_HOLD (word buffered, req=0), S_DROP (req=1 with stale addr, result discarded).
- S_FETCH, ack & !stall: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay.
- S_FETCH, ack & stall: skid buffer <= {rdata, pc+4}; pc <= pc+4; -> S_HOLD; IF/ID unchanged.
- S_FETCH, !ack: IF/ID <= bubble (instr 0, valid 0) if !stall, else hold.
- S_HOLD, !stall: IF/ID <= skid buffer, valid=1; -> S_FETCH. S_HOLD, stall: hold.
- pc_jump is ignored while stall=1. With !stall: pc <= {jump_target[31:2],2'b00}; IF/ID <= bubble; skid buffer discarded; in S_FETCH with ack this cycle the word is dropped and state stays S_FETCH; in S_FETCH without ack -> S_DROP (address must not change mid-handshake).
- flush: same as redirect but pc unchanged beyond normal advance is NOT kept: a word acked this cycle is discarded and pc is not incremented; flush overrides stall for IF/ID (IF/ID <= bubble).
- S_DROP: keep req and old addr; on ack discard data, -> S_FETCH with new pc. Further redirect in S_DROP just updates pc.
- Priority: rst > flush > pc_jump > stall > normal.
- PC arithmetic modulo 2^32: pc 32'hFFFF_FFFC advances to 0.

## Timing
- Reset: pc=RESET_PC, state S_FETCH, IF/ID instr=0, pc4=0, valid=0, skid empty; imem_req=1 the first cycle after rst deasserts.
- Latency: word acked in cycle N appears on ifid_* in cycle N+1.
- Back-to-back: with ack tied high, one instruction per cycle.
- Redirect penalty: jr in ID cycle N -> first target word on ifid_* at N+2 (one bubble) with zero-latency memory.
- imem_req/imem_addr are functions of state and pc registers only (no combinational path from stall/ack).
- rst asserted mid-handshake abandons the request; memory must tolerate req dropping.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs perf_fetched (32) counting IF/ID loads with valid=1 and perf_stall (32) counting cycles with stall=1; both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared pipeline constants header: NOP encoding 32'h0000_0000, state encodings S_FETCH/S_HOLD/S_DROP, default RESET_PC.
- One sub-module: if_skid_buffer (one-entry {instr, pc4} holding register with load/clear/valid).
- PC register, FSM and IF/ID register live in if_stage.

## Test plan
- Reset then ack=1 every cycle, mem[i]=i+1: ifid_instr 1,2,3…, ifid_pc4 4,8,12…, valid from cycle 2.
- stall high 3 cycles while ack=1: IF/ID frozen, imem_req low in S_HOLD, buffered word released on stall fall, no word lost or duplicated.
- pc_jump with target 32'h0000_0103: next fetch address 32'h0000_0100, one bubble (valid=0, instr=0) on IF/ID.
- Redirect while ack withheld 2 cycles: addr held stable until ack, returned word discarded, next req at target.
- flush and stall together with ack=1: IF/ID becomes bubble, pc not incremented, same address re-requested.
- RESET_PC=32'hFFFF_FFFC: second fetch address 0; with IF_PERF_CNT_EN, perf_fetched equals count of valid IF/ID loads.
